// File: rtl/nnsim_pkg.sv
// Shared constants for the NN simulator datapath.
package nnsim_pkg;

  localparam int REG_WIDTH     = 32;
  localparam int NUM_ADDR_BITS = 6;

  localparam logic [REG_WIDTH-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard. A reserve marks a register busy and a write
// clears it. When both hit one address in one cycle the reserve wins, because
// the reserve names the newer producer. Read ports see busy masked by any
// same-cycle write to the address they read.
module regfile_scoreboard #(
  parameter int NUM_ADDR_BITS = 6,
  parameter int NUM_REGS      = 64,
  parameter int NUM_RD        = 3,
  parameter int NUM_WR        = 1,
  parameter int ZERO_REG      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WR-1:0]               wr_valid,
  input  logic [NUM_WR*NUM_ADDR_BITS-1:0] wr_addr,
  input  logic                            rsv_enable,
  input  logic [NUM_ADDR_BITS-1:0]        rsv_addr,
  input  logic [NUM_RD*NUM_ADDR_BITS-1:0] rd_addr,
  input  logic [NUM_RD-1:0]               rd_hit,
  output logic [NUM_RD-1:0]               rd_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                rsv_valid;

  // The hardwired zero register can never have a pending producer.
  assign rsv_valid = rsv_enable && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Next busy vector: clear on write first, then set on reserve so the reserve wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_valid[i]) begin
        busy_d[wr_addr[i*NUM_ADDR_BITS +: NUM_ADDR_BITS]] = 1'b0;
      end
    end
    if (rsv_valid) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // Busy register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar gj = 0; gj < NUM_RD; gj++) begin : g_rd_busy
    // A write landing this cycle retires the producer, so the reader is not stalled.
    assign rd_busy[gj] = busy_q[rd_addr[gj*NUM_ADDR_BITS +: NUM_ADDR_BITS]] & ~rd_hit[gj];
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-first bypass, optional
// hardwired-zero register 0 and a busy scoreboard for RAW hazard detection.
// NUM_REGS is expected to equal 2**NUM_ADDR_BITS so every address is valid.
module regfile_mp #(
  parameter int NUM_ADDR_BITS = nnsim_pkg::NUM_ADDR_BITS,
  parameter int REG_WIDTH     = nnsim_pkg::REG_WIDTH,
  parameter int NUM_REGS      = 2**NUM_ADDR_BITS,
  parameter int NUM_RD        = 3,
  parameter int NUM_WR        = 1,
  parameter int ZERO_REG      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WR-1:0]               writeEnable,
  input  logic [NUM_WR*NUM_ADDR_BITS-1:0] wrAddr,
  input  logic [NUM_WR*REG_WIDTH-1:0]     wrData,
  input  logic [NUM_RD*NUM_ADDR_BITS-1:0] rdAddr,
  output logic [NUM_RD*REG_WIDTH-1:0]     rdData,
  output logic [NUM_RD-1:0]               rdBusy,
  input  logic                            rsvEnable,
  input  logic [NUM_ADDR_BITS-1:0]        rsvAddr
);

  import nnsim_pkg::*;

  localparam logic [REG_WIDTH-1:0] ZERO_VAL = REG_WIDTH'(ZERO_WORD);

  logic [NUM_ADDR_BITS-1:0] wr_addr_a [NUM_WR];
  logic [REG_WIDTH-1:0]     wr_data_a [NUM_WR];
  logic [NUM_WR-1:0]        wr_valid;
  logic [NUM_ADDR_BITS-1:0] rd_addr_a [NUM_RD];
  logic [NUM_RD-1:0]        rd_hit;
  logic [REG_WIDTH-1:0]     regs_q [NUM_REGS];
  logic [REG_WIDTH-1:0]     regs_d [NUM_REGS];

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
    assign wr_addr_a[gi] = wrAddr[gi*NUM_ADDR_BITS +: NUM_ADDR_BITS];
    assign wr_data_a[gi] = wrData[gi*REG_WIDTH +: REG_WIDTH];
    // Writes to the hardwired zero register are dropped at the source so
    // neither the array, the bypass nor the scoreboard ever sees them.
    assign wr_valid[gi]  = writeEnable[gi] && !((ZERO_REG != 0) && (wr_addr_a[gi] == '0));
  end

  // Next array contents; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_valid[i]) begin
        regs_d[wr_addr_a[i]] = wr_data_a[i];
      end
    end
  end

  // Register array with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= ZERO_VAL;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar gj = 0; gj < NUM_RD; gj++) begin : g_rd
    logic [NUM_WR-1:0]    hit_vec;
    logic [REG_WIDTH-1:0] rd_word;

    assign rd_addr_a[gj] = rdAddr[gj*NUM_ADDR_BITS +: NUM_ADDR_BITS];

    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_hit
      assign hit_vec[gi] = wr_valid[gi] && (wr_addr_a[gi] == rd_addr_a[gj]);
    end

    // Write-first read mux: highest hitting write port, else the array; zero
    // register and reset force the word to zero.
    always_comb begin
      rd_word = regs_q[rd_addr_a[gj]];
      for (int i = 0; i < NUM_WR; i++) begin
        if (hit_vec[i]) begin
          rd_word = wr_data_a[i];
        end
      end
      if (rst || ((ZERO_REG != 0) && (rd_addr_a[gj] == '0))) begin
        rd_word = ZERO_VAL;
      end
    end

    assign rd_hit[gj]                          = |hit_vec;
    assign rdData[gj*REG_WIDTH +: REG_WIDTH]   = rd_word;
  end

  regfile_scoreboard #(
    .NUM_ADDR_BITS (NUM_ADDR_BITS),
    .NUM_REGS      (NUM_REGS),
    .NUM_RD        (NUM_RD),
    .NUM_WR        (NUM_WR),
    .ZERO_REG      (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_addr    (wrAddr),
    .rsv_enable (rsvEnable),
    .rsv_addr   (rsvAddr),
    .rd_addr    (rdAddr),
    .rd_hit     (rd_hit),
    .rd_busy    (rdBusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp configured with 4 read ports, 2 write ports,
// 16 registers and a hardwired zero register.
module tb_regfile_mp;

  localparam int AB = 4;
  localparam int RW = 32;
  localparam int NR = 4;
  localparam int NW = 2;

  logic               clk;
  logic               rst;
  logic [1:0]         we;
  logic [AB-1:0]      wa [NW];
  logic [RW-1:0]      wd [NW];
  logic               rsv;
  logic [AB-1:0]      rsa;
  logic [AB-1:0]      ra [NR];
  logic [NW*AB-1:0]   wr_addr_w;
  logic [NW*RW-1:0]   wr_data_w;
  logic [NR*AB-1:0]   rd_addr_w;
  logic [NR*RW-1:0]   rd_data_w;
  logic [NR-1:0]      rd_busy_w;

  int checks;
  int errors;

  assign wr_addr_w = {wa[1], wa[0]};
  assign wr_data_w = {wd[1], wd[0]};
  assign rd_addr_w = {ra[3], ra[2], ra[1], ra[0]};

  regfile_mp #(
    .NUM_ADDR_BITS (AB),
    .REG_WIDTH     (RW),
    .NUM_REGS      (16),
    .NUM_RD        (NR),
    .NUM_WR        (NW),
    .ZERO_REG      (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .writeEnable (we),
    .wrAddr      (wr_addr_w),
    .wrData      (wr_data_w),
    .rdAddr      (rd_addr_w),
    .rdData      (rd_data_w),
    .rdBusy      (rd_busy_w),
    .rsvEnable   (rsv),
    .rsvAddr     (rsa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      we;
    logic [AB-1:0]   wa0;
    logic [RW-1:0]   wd0;
    logic [AB-1:0]   wa1;
    logic [RW-1:0]   wd1;
    logic            rsv;
    logic [AB-1:0]   rsa;
    logic [15:0]     ra;   // nibble k = read address of port k
    logic [127:0]    ed;   // word k = expected data of port k
    logic [3:0]      eb;   // bit k = expected busy of port k
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic [1:0] we_i, input logic [3:0] wa0_i,
                              input logic [31:0] wd0_i, input logic [3:0] wa1_i,
                              input logic [31:0] wd1_i, input logic rsv_i,
                              input logic [3:0] rsa_i, input logic [15:0] ra_i,
                              input logic [127:0] ed_i, input logic [3:0] eb_i);
    vec_t v;
    v.we = we_i; v.wa0 = wa0_i; v.wd0 = wd0_i; v.wa1 = wa1_i; v.wd1 = wd1_i;
    v.rsv = rsv_i; v.rsa = rsa_i; v.ra = ra_i; v.ed = ed_i; v.eb = eb_i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    rsv = 1'b0; rsa = '0;
  endtask

  task automatic set_ra(input logic [15:0] r);
    for (int k = 0; k < NR; k++) ra[k] = r[k*4 +: 4];
  endtask

  task automatic chk_all(input string tag, input logic [127:0] ed, input logic [3:0] eb);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s_data%0d", tag, k), rd_data_w[k*RW +: RW], ed[k*32 +: 32]);
      chk($sformatf("%s_busy%0d", tag, k), 32'(rd_busy_w[k]), 32'(eb[k]));
    end
  endtask

  // Reference model state for the random phase.
  logic [RW-1:0] m_regs [16];
  logic [15:0]   m_busy;

  initial begin
    checks = 0;
    errors = 0;

    //            we     wa0   wd0           wa1   wd1          rsv   rsa   ra         expected data (port3..port0)                          busy
    vecs[0]  = mk(2'b01, 4'd5, 32'h1234,     4'd0, 32'h0,       1'b0, 4'd0, 16'h0005, {32'h0, 32'h0, 32'h0, 32'h1234},                        4'b0000);
    vecs[1]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,       1'b0, 4'd0, 16'h0005, {32'h0, 32'h0, 32'h0, 32'h1234},                        4'b0000);
    vecs[2]  = mk(2'b01, 4'd7, 32'hDEADBEEF, 4'd0, 32'h0,       1'b0, 4'd0, 16'h0057, {32'h0, 32'h0, 32'h1234, 32'hDEADBEEF},                 4'b0000);
    vecs[3]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,       1'b0, 4'd0, 16'h0057, {32'h0, 32'h0, 32'h1234, 32'hDEADBEEF},                 4'b0000);
    vecs[4]  = mk(2'b10, 4'd0, 32'h0,        4'd0, 32'hFFFFFFFF,1'b0, 4'd0, 16'h0070, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},                    4'b0000);
    vecs[5]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,       1'b0, 4'd0, 16'h0070, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},                    4'b0000);
    vecs[6]  = mk(2'b11, 4'd3, 32'h1,        4'd3, 32'h2,       1'b0, 4'd0, 16'h0003, {32'h0, 32'h0, 32'h0, 32'h2},                           4'b0000);
    vecs[7]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,       1'b0, 4'd0, 16'h0003, {32'h0, 32'h0, 32'h0, 32'h2},                           4'b0000);
    vecs[8]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,       1'b1, 4'd9, 16'h0099, {32'h0, 32'h0, 32'h0, 32'h0},                           4'b0000);
    vecs[9]  = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,       1'b0, 4'd0, 16'h0099, {32'h0, 32'h0, 32'h0, 32'h0},                           4'b0011);
    vecs[10] = mk(2'b01, 4'd9, 32'h55,       4'd0, 32'h0,       1'b0, 4'd0, 16'h0099, {32'h0, 32'h0, 32'h55, 32'h55},                         4'b0000);
    vecs[11] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,       1'b0, 4'd0, 16'h0099, {32'h0, 32'h0, 32'h55, 32'h55},                         4'b0000);
    vecs[12] = mk(2'b10, 4'd0, 32'h0,        4'd9, 32'h66,      1'b1, 4'd9, 16'h0099, {32'h0, 32'h0, 32'h66, 32'h66},                         4'b0000);
    vecs[13] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,       1'b0, 4'd0, 16'h0099, {32'h0, 32'h0, 32'h66, 32'h66},                         4'b0011);
    vecs[14] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,       1'b1, 4'd0, 16'h0000, {32'h0, 32'h0, 32'h0, 32'h0},                           4'b0000);
    vecs[15] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,       1'b0, 4'd0, 16'h0090, {32'h0, 32'h0, 32'h66, 32'h0},                          4'b0010);
    vecs[16] = mk(2'b11, 4'hA, 32'hA,        4'hB, 32'hB,       1'b0, 4'd0, 16'h75BA, {32'hDEADBEEF, 32'h1234, 32'hB, 32'hA},                 4'b0000);
    vecs[17] = mk(2'b00, 4'd0, 32'h0,        4'd0, 32'h0,       1'b0, 4'd0, 16'h375B, {32'h2, 32'hDEADBEEF, 32'h1234, 32'hB},                 4'b0000);

    // Reset state: a write presented during reset must not show up anywhere.
    rst = 1'b1;
    idle_inputs();
    we = 2'b01; wa[0] = 4'd5; wd[0] = 32'h99;
    set_ra(16'h0005);
    #3;
    chk_all("reset", 128'h0, 4'b0000);
    $display("reset rd_data=%h rd_busy=%b", rd_data_w, rd_busy_w);
    #8;
    idle_inputs();
    #1;
    rst = 1'b0;

    // Directed vectors, one per cycle, checked mid-cycle before the commit edge.
    for (int n = 0; n < 18; n++) begin
      @(posedge clk);
      #1;
      we = vecs[n].we;
      wa[0] = vecs[n].wa0; wd[0] = vecs[n].wd0;
      wa[1] = vecs[n].wa1; wd[1] = vecs[n].wd1;
      rsv = vecs[n].rsv; rsa = vecs[n].rsa;
      set_ra(vecs[n].ra);
      @(negedge clk);
      chk_all($sformatf("vec%0d", n), vecs[n].ed, vecs[n].eb);
      $display("vec %0d we=%b ra=%h rd_data=%h rd_busy=%b", n, we, vecs[n].ra, rd_data_w, rd_busy_w);
    end

    // Mid-run reset: reserve r4 first, then pulse rst with traffic present.
    @(posedge clk);
    #1;
    idle_inputs();
    rsv = 1'b1; rsa = 4'd4;
    set_ra(16'h8465);
    @(posedge clk);
    #1;
    rsv = 1'b0;
    @(negedge clk);
    chk("pre_rst_r5", rd_data_w[31:0], 32'h1234);
    chk("pre_rst_busy_r4", 32'(rd_busy_w[2]), 32'h1);
    #1;
    rst = 1'b1;
    we = 2'b01; wa[0] = 4'd6; wd[0] = 32'h77;
    rsv = 1'b1; rsa = 4'd8;
    #1;
    chk_all("in_rst", 128'h0, 4'b0000);
    $display("in_rst rd_data=%h rd_busy=%b", rd_data_w, rd_busy_w);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    rst = 1'b0;
    #1;
    chk_all("post_rst", 128'h0, 4'b0000);
    @(posedge clk);
    #1;
    chk_all("post_rst_edge", 128'h0, 4'b0000);
    $display("post_rst rd_data=%h rd_busy=%b", rd_data_w, rd_busy_w);

    // Random phase against a behavioural model; state is all zero after reset.
    for (int r = 0; r < 16; r++) m_regs[r] = '0;
    m_busy = '0;
    for (int c = 0; c < 1000; c++) begin
      logic [31:0] exp_d;
      logic        hit;
      int          bad_before;
      @(posedge clk);
      #1;
      we    = 2'($urandom_range(0, 3));
      wa[0] = 4'($urandom_range(0, 15));
      wa[1] = 4'($urandom_range(0, 15));
      wd[0] = $urandom;
      wd[1] = $urandom;
      rsv   = 1'($urandom_range(0, 1));
      rsa   = 4'($urandom_range(0, 15));
      for (int k = 0; k < NR; k++) ra[k] = 4'($urandom_range(0, 15));
      @(negedge clk);
      bad_before = errors;
      for (int k = 0; k < NR; k++) begin
        exp_d = m_regs[ra[k]];
        hit = 1'b0;
        for (int i = 0; i < NW; i++) begin
          if (we[i] && wa[i] != 4'd0 && wa[i] == ra[k]) begin
            exp_d = wd[i];
            hit = 1'b1;
          end
        end
        if (ra[k] == 4'd0) exp_d = 32'h0;
        chk($sformatf("rnd%0d_data%0d", c, k), rd_data_w[k*RW +: RW], exp_d);
        chk($sformatf("rnd%0d_busy%0d", c, k), 32'(rd_busy_w[k]), 32'(m_busy[ra[k]] & ~hit));
      end
      if (errors != bad_before)
        $display("rnd %0d we=%b wa=%h/%h rsv=%b rsa=%h ra=%h", c, we, wa[0], wa[1], rsv, rsa, rd_addr_w);
      // Commit the model as the coming edge will.
      for (int i = 0; i < NW; i++) begin
        if (we[i] && wa[i] != 4'd0) begin
          m_regs[wa[i]] = wd[i];
          m_busy[wa[i]] = 1'b0;
        end
      end
      if (rsv && rsa != 4'd0) m_busy[rsa] = 1'b1;
    end
    $display("random phase done after 1000 cycles");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the NN simulator datapath. It replaces the fixed three-read/one-write file with configurable read ports (NUM_RD), write ports (NUM_WR), an optional hardwired-zero register, same-cycle write-to-read bypass, and a per-register busy scoreboard. The scoreboard lets the issue stage detect read-after-write hazards without a separate unit.

## Interface
- NUM_ADDR_BITS, 6: register address width.
- REG_WIDTH, 32: data width.
- NUM_REGS, 2**NUM_ADDR_BITS: register count.
- NUM_RD, 3: read ports.
- NUM_WR, 1: write ports.
- ZERO_REG, 1: when 1, register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- writeEnable  in  NUM_WR  per-port write strobe.
- wrAddr  in  NUM_WR*NUM_ADDR_BITS  write addresses; port i is slice [i*NUM_ADDR_BITS +: NUM_ADDR_BITS].
- wrData  in  NUM_WR*REG_WIDTH  write data, packed the same way.
- rdAddr  in  NUM_RD*NUM_ADDR_BITS  read addresses.
- rdData  out  NUM_RD*REG_WIDTH  read data, combinational.
- rdBusy  out  NUM_RD  1 = the addressed register has a pending producer.
- rsvEnable  in  1  reserve strobe: marks a register busy.
- rsvAddr  in  NUM_ADDR_BITS  register to reserve.

## Operation
- Storage: the NUM_REGS x REG_WIDTH array `regs` and the busy bit vector `busy` (NUM_REGS bits).
- Write: on the rising clk edge, for each port i with writeEnable[i], `regs[wrAddr_i]` takes wrData_i.
  - With ZERO_REG=1, writes to address 0 are dropped.
  - If several ports write the same address in one cycle, the highest-indexed port wins.
- Read port j:
  - If any enabled write port targets rdAddr_j this cycle (and the address is not a ZERO_REG 0), rdData_j returns that port's wrData, highest index winning. This is write-first bypass.
  - Otherwise rdData_j returns `regs[rdAddr_j]`.
  - Address 0 with ZERO_REG=1 always returns 0.
- Scoreboard:
  - A write to address a clears busy[a].
  - rsvEnable sets busy[rsvAddr].
  - A reserve and a write to the same address in the same cycle leave busy set: the reserve wins because it names a newer producer.
  - Reserving address 0 with ZERO_REG=1 has no effect.
- rdBusy_j = busy[rdAddr_j] AND NOT (a same-cycle write hits rdAddr_j). A reserve issued in the current cycle is not reflected until the next cycle.
- Address range: NUM_REGS must equal 2**NUM_ADDR_BITS, so no out-of-range addresses exist.

## Timing
- Reset: asserting rst asynchronously clears every register and every busy bit.
  - While rst is held, rdData returns 0 and rdBusy returns 0 on every port.
  - Writes and reserves presented during reset are lost.
  - The first rising edge after rst deasserts performs a normal update.
- Write latency: 1 edge into the array; 0 cycles to a same-cycle reader through the bypass.
- Busy set latency: 1 edge after rsvEnable.
- Busy clear: visible at the read port in the same cycle as the write (bypass), and registered on the next edge.
- Paths: read data and busy have purely combinational paths from the addresses, writeEnable and wrData. There is no handshake and no backpressure.

## Structure
- Shared package `nnsim_pkg` holds:
  - the default constants REG_WIDTH=32 and NUM_ADDR_BITS=6;
  - the zero word constant.
- The module keeps its own parameters so that it can be overridden per instance.
- Sub-module `regfile_scoreboard` holds the busy vector, the set/clear priority and the rdBusy masking. The data array and bypass muxes stay in `regfile_mp`.
- Bypass and write-priority logic are generated with generate loops over NUM_RD and NUM_WR.

## Test plan
- Reset and zero register:
  - Pulse rst mid-run after writing r5=0x1234 → r5 reads 0 and all rdBusy are 0.
  - Write r0=0xFFFF_FFFF with ZERO_REG=1 → r0 reads 0.
- Bypass:
  - Write r7=0xDEAD_BEEF while rdAddr_0=7 in the same cycle → rdData_0=0xDEAD_BEEF before the edge, and it persists after the edge.
- Write conflict (NUM_WR=2):
  - Ports 0 and 1 both write r3, with 0x1 and 0x2 → r3=0x2, and the bypassed read also shows 0x2.
- Scoreboard sequence:
  - Reserve r9, then read r9 next cycle → rdBusy=1.
  - Write r9=0x55 → rdBusy=0 in the same cycle and data is 0x55.
  - Reserve and write r9 in one cycle → busy=1 on the next cycle.
- Parameter sweep:
  - NUM_RD=4, NUM_WR=2, NUM_ADDR_BITS=4, 1000 random cycles against a reference model → every read matches.
  - NUM_RD=4, NUM_WR=2, NUM_ADDR_BITS=4, 1000 random cycles against a reference model → every busy bit matches.
